cache_bus_responder: RTL

CACHE_BUS_RESPONDER -- requirements
Module: cache_bus_responder

---
 rtl/cache_bus_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cache_bus_responder.sv
// Cache line fill / writeback burst engine.
// Splits one line request into beat-sized memory transactions.
module cache_bus_responder #(
  parameter int PA_BITS = 34,
  parameter int LINELEN = 256,
  parameter int BEATLEN = 64,
  parameter int LOGBWPL = $clog2(LINELEN/BEATLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [BEATLEN-1:0] CacheWriteBeat,
  output logic               CacheBusAck,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               SelBusBeat,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               CacheBusCommitted,
  output logic               MemValid,
  output logic               MemWrite,
  output logic [PA_BITS-1:0] MemAdr,
  output logic [BEATLEN-1:0] MemWData,
  input  logic               MemReady,
  input  logic [BEATLEN-1:0] MemRData
);

  localparam int NBEATS   = LINELEN / BEATLEN;
  localparam int BYTE_OFF = $clog2(BEATLEN / 8);
  localparam int LINE_OFF = $clog2(LINELEN / 8);
  localparam int TAG_W    = PA_BITS - LINE_OFF;
  localparam logic [LOGBWPL-1:0] LAST_BEAT = LOGBWPL'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [LOGBWPL-1:0]   beat_q, beat_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [LINELEN-1:0]   fetch_q, fetch_d;

  logic busy;
  logic beat_done;
  logic last_beat;
  logic unused_off;

  // Byte offset within the line is recomputed from the beat counter.
  assign unused_off = ^CacheBusAdr[LINE_OFF-1:0];

  assign busy      = (state_q == WRITE) || (state_q == READ);
  assign beat_done = busy && MemReady;
  assign last_beat = beat_done && (beat_q == LAST_BEAT);

  // Next-state, beat counter and fill-buffer assembly.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tag_d   = tag_q;
    fetch_d = fetch_q;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        if (CacheBusRW[0]) begin
          state_d = WRITE;
          tag_d   = CacheBusAdr[PA_BITS-1:LINE_OFF];
        end else if (CacheBusRW[1]) begin
          state_d = READ;
          tag_d   = CacheBusAdr[PA_BITS-1:LINE_OFF];
        end
      end
      WRITE: begin
        if (beat_done) begin
          beat_d = beat_q + LOGBWPL'(1);
        end
        if (last_beat) begin
          beat_d  = '0;
          state_d = CacheBusRW[1] ? READ : DONE;
        end
      end
      READ: begin
        if (beat_done) begin
          beat_d = beat_q + LOGBWPL'(1);
          for (int i = 0; i < NBEATS; i++) begin
            if (beat_q == LOGBWPL'(i)) begin
              fetch_d[i*BEATLEN +: BEATLEN] = MemRData;
            end
          end
        end
        if (last_beat) begin
          beat_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tag_q   <= '0;
      fetch_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tag_q   <= tag_d;
      fetch_q <= fetch_d;
    end
  end

  // A writeback followed by a fill acks only at the end of the fill.
  assign CacheBusAck = last_beat &&
                       ((state_q == READ) || !CacheBusRW[1]);

  assign BeatCount         = beat_q;
  assign SelBusBeat        = busy;
  assign CacheBusCommitted = busy;
  assign FetchBuffer       = fetch_q;
  assign MemValid          = busy;
  assign MemWrite          = (state_q == WRITE);
  assign MemWData          = CacheWriteBeat;
  assign MemAdr            = {tag_q, beat_q, {BYTE_OFF{1'b0}}};

endmodule
